// File: rtl/traffic_sig_controller_param_if.sv
// Signal-head bundle for the highway/country intersection controller.
// master = controller side, slave = sensor/lamp side.
interface traffic_sig_controller_param_if;
   logic       CAR_ON_CNTRY_RD;
   logic [1:0] HWY_SIG;
   logic [1:0] CNTRY_SIG;
   logic [2:0] PHASE;
   logic       CNTRY_REQ;

   modport master (
      input  CAR_ON_CNTRY_RD,
      output HWY_SIG,
      output CNTRY_SIG,
      output PHASE,
      output CNTRY_REQ
   );

   modport slave (
      output CAR_ON_CNTRY_RD,
      input  HWY_SIG,
      input  CNTRY_SIG,
      input  PHASE,
      input  CNTRY_REQ
   );
endinterface

// File: rtl/traffic_sig_controller_param.sv
// Parametrised highway/country intersection controller.
// Moore FSM with one shared saturating down-counter and latched car request.
module traffic_sig_controller_param #(
   parameter int Y2RDELAY        = 3,
   parameter int R2GDELAY        = 2,
   parameter int HWY_MIN_GREEN   = 8,
   parameter int CNTRY_MAX_GREEN = 10,
   parameter int CNT_W           = 8
) (
   input  logic CLK,
   input  logic CLEAR_N,
   traffic_sig_controller_param_if.master sig
);

   localparam int MAXA = (Y2RDELAY > R2GDELAY) ? Y2RDELAY : R2GDELAY;
   localparam int MAXB = (HWY_MIN_GREEN > CNTRY_MAX_GREEN) ?
                         HWY_MIN_GREEN : CNTRY_MAX_GREEN;
   localparam int MAXP = (MAXA > MAXB) ? MAXA : MAXB;

   if (Y2RDELAY < 1 || R2GDELAY < 1 ||
       HWY_MIN_GREEN < 1 || CNTRY_MAX_GREEN < 1) begin : g_bad_dly
      $error("phase durations must all be >= 1");
   end

   if ((MAXP - 1) >= (1 << CNT_W)) begin : g_bad_w
      $error("CNT_W too narrow for the longest phase");
   end

   localparam logic [CNT_W-1:0] Y2R_LD  = CNT_W'(Y2RDELAY - 1);
   localparam logic [CNT_W-1:0] R2G_LD  = CNT_W'(R2GDELAY - 1);
   localparam logic [CNT_W-1:0] HMIN_LD = CNT_W'(HWY_MIN_GREEN - 1);
   localparam logic [CNT_W-1:0] CMAX_LD = CNT_W'(CNTRY_MAX_GREEN - 1);

   localparam logic [1:0] RED = 2'd0;
   localparam logic [1:0] YEL = 2'd1;
   localparam logic [1:0] GRN = 2'd2;

   typedef enum logic [2:0] {
      S0 = 3'd0,
      S1 = 3'd1,
      S2 = 3'd2,
      S3 = 3'd3,
      S4 = 3'd4,
      S5 = 3'd5
   } state_t;

   state_t           state_q, state_d;
   logic [CNT_W-1:0] tmr_q, tmr_d;
   logic             req_q, req_d;
   logic [1:0]       hwy_q, cntry_q;
   logic             car, req, tmr_done;

   function automatic logic [1:0] hwy_of(state_t s);
      case (s)
         S0:      hwy_of = GRN;
         S1:      hwy_of = YEL;
         default: hwy_of = RED;
      endcase
   endfunction

   function automatic logic [1:0] cntry_of(state_t s);
      case (s)
         S3:      cntry_of = GRN;
         S4:      cntry_of = YEL;
         default: cntry_of = RED;
      endcase
   endfunction

   assign car      = sig.CAR_ON_CNTRY_RD;
   assign req      = req_q | car;
   assign tmr_done = (tmr_q == '0);

   // Next state, timer reload/decrement and request latch.
   always_comb begin
      state_d = state_q;
      tmr_d   = tmr_done ? '0 : tmr_q - CNT_W'(1);
      case (state_q)
         S0: if (tmr_done && req) begin
            state_d = S1;
            tmr_d   = Y2R_LD;
         end
         S1: if (tmr_done) begin
            state_d = S2;
            tmr_d   = R2G_LD;
         end
         S2: if (tmr_done) begin
            state_d = S3;
            tmr_d   = CMAX_LD;
         end
         S3: if (!car || tmr_done) begin
            state_d = S4;
            tmr_d   = Y2R_LD;
         end
         S4: if (tmr_done) begin
            state_d = S5;
            tmr_d   = R2G_LD;
         end
         S5: if (tmr_done) begin
            state_d = S0;
            tmr_d   = HMIN_LD;
         end
         default: begin
            state_d = S5;
            tmr_d   = R2G_LD;
         end
      endcase

      req_d = req_q;
      if (car && state_q != S3) req_d = 1'b1;
      if (state_d == S3 && state_q != S3) req_d = 1'b0;
   end

   // State, timer, request and signal heads all move on the same edge.
   always_ff @(posedge CLK or negedge CLEAR_N) begin
      if (!CLEAR_N) begin
         state_q <= S0;
         tmr_q   <= HMIN_LD;
         req_q   <= 1'b0;
         hwy_q   <= GRN;
         cntry_q <= RED;
      end else begin
         state_q <= state_d;
         tmr_q   <= tmr_d;
         req_q   <= req_d;
         hwy_q   <= hwy_of(state_d);
         cntry_q <= cntry_of(state_d);
      end
   end

   assign sig.HWY_SIG   = hwy_q;
   assign sig.CNTRY_SIG = cntry_q;
   assign sig.PHASE     = state_q;
   assign sig.CNTRY_REQ = req_q;

endmodule
